param_cacheline_adaptor: RTL and testbench

Burst adaptor between the cache datapath and main memory. Converts one 256-bit cache line transfer (fill into the data array, or writeback of a line read out of it) into a sequence of narrow memory bursts, and reassembles incoming bursts into a full line. It sits directly below the cache data array: its `line_o` feeds the array's write data on a fill, and the array's read data drives `line_i` on a writeback.

---
 rtl/param_cacheline_adaptor_if.sv | 33 +++
 rtl/param_cacheline_adaptor.sv | 110 +++++++++++
 tb/tb_param_cacheline_adaptor.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/param_cacheline_adaptor_if.sv
// Cache-line / memory-burst bus bundle for param_cacheline_adaptor.
// Signal names keep their _i/_o suffixes as seen from the adaptor.
// The adaptor connects through the slave modport. The cache/memory
// environment connects through the master modport.
interface param_cacheline_adaptor_if #(
  parameter int LINE_BITS  = 256,
  parameter int BURST_BITS = 64
);
  // cache side
  logic                  read_i;
  logic                  write_i;
  logic [31:0]           address_i;
  logic [LINE_BITS-1:0]  line_i;
  logic [LINE_BITS-1:0]  line_o;
  logic                  resp_o;
  // memory side
  logic [31:0]           address_o;
  logic                  read_o;
  logic                  write_o;
  logic [BURST_BITS-1:0] burst_o;
  logic [BURST_BITS-1:0] burst_i;
  logic                  resp_i;

  modport slave (
    input  read_i, write_i, address_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  modport master (
    output read_i, write_i, address_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );
endinterface

// File: rtl/param_cacheline_adaptor.sv
// Burst adaptor between the cache data array and main memory.
// A line fill assembles BEATS memory beats into one line buffer.
// A writeback latches a whole line and streams it out one beat at a time.
// Beats go lowest slice first. Reset is synchronous and active-high.
module param_cacheline_adaptor #(
  parameter int LINE_BITS  = 256,
  parameter int BURST_BITS = 64,
  parameter int BEATS      = LINE_BITS / BURST_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  param_cacheline_adaptor_if.slave bus
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFS   = $clog2(LINE_BITS / 8);
  // clears the byte-within-line offset bits of the request address
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFS) - 32'd1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [LINE_BITS-1:0] line_q;
  logic [31:0]          addr_q;
  logic                 read_q;
  logic                 write_q;
  logic                 resp_q;

  // Transfer FSM. read_o, write_o and resp_o are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_q <= 1'b0;
          // Writeback wins over a simultaneous fill request.
          if (bus.write_i) begin
            state   <= WRITE;
            write_q <= 1'b1;
            addr_q  <= bus.address_i & ADDR_MASK;
            cnt     <= '0;
            line_q  <= bus.line_i;
          end else if (bus.read_i) begin
            state  <= READ;
            read_q <= 1'b1;
            addr_q <= bus.address_i & ADDR_MASK;
            cnt    <= '0;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            line_q[BURST_BITS*cnt +: BURST_BITS] <= bus.burst_i;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state  <= DONE;
              read_q <= 1'b0;
              resp_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (bus.resp_i) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state   <= DONE;
              write_q <= 1'b0;
              resp_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          // resp_o is a single-cycle pulse, and IDLE is always re-entered.
          resp_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state   <= IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  // Outputs. Only the write beat is combinational. It selects the current
  // slice and is gated to zero outside a writeback.
  assign bus.line_o    = line_q;
  assign bus.address_o = addr_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;
  assign bus.burst_o   = write_q ? line_q[BURST_BITS*cnt +: BURST_BITS]
                                 : '0;

endmodule

// File: tb/tb_param_cacheline_adaptor.sv
// Self-checking bench for param_cacheline_adaptor.
// Directed steps come first, followed by randomized reads and writes.
// Each transfer is checked against a transaction-level model of beat order,
// address alignment, latency and the assembled line.
module tb_param_cacheline_adaptor;
  localparam int LB = 256;
  localparam int BB = 64;
  localparam int NB = LB / BB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  param_cacheline_adaptor_if #(.LINE_BITS(LB), .BURST_BITS(BB)) bus ();

  param_cacheline_adaptor #(.LINE_BITS(LB), .BURST_BITS(BB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return (a >> 5) << 5;
  endfunction

  function automatic logic [LB-1:0] rnd_line();
    logic [LB-1:0] l;
    for (int i = 0; i < LB / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read_o"},    bus.read_o,    '0);
    chk({tag, "_write_o"},   bus.write_o,   '0);
    chk({tag, "_resp_o"},    bus.resp_o,    '0);
    chk({tag, "_address_o"}, bus.address_o, '0);
    chk({tag, "_burst_o"},   bus.burst_o,   '0);
    chk({tag, "_line_o"},    bus.line_o,    '0);
  endtask

  // Fill: memory supplies the beats of 'line' in order.
  // When pat_len > 0, bit n of 'pat' gives resp_i for beat-cycle n. Otherwise resp_i is random.
  task automatic read_xfer(input logic [31:0] addr, input logic [LB-1:0] line,
                           input int pat_len, input logic [31:0] pat, input bit hold);
    int k = 0, n = 0, stalls = 0, cycles;
    logic r;
    bus.write_i   = 1'b0;
    bus.read_i    = 1'b1;
    bus.address_i = addr;
    cyc();
    cycles = 1;
    chk("rd_address_o", bus.address_o, align(addr));
    while (k < NB && n < 64) begin
      r = (pat_len > 0) ? pat[n] : ($urandom_range(0, 3) != 0);
      chk("rd_read_o", bus.read_o, 1'b1);
      chk("rd_write_o", bus.write_o, 1'b0);
      chk("rd_resp_o_early", bus.resp_o, 1'b0);
      bus.resp_i  = r;
      bus.burst_i = line[k*BB +: BB];
      cyc();
      cycles++;
      n++;
      if (r) k++; else stalls++;
    end
    if (k < NB) chk("rd_timeout", k, NB);
    bus.resp_i  = 1'b0;
    bus.burst_i = $urandom;
    chk("rd_resp_o", bus.resp_o, 1'b1);
    chk("rd_read_o_done", bus.read_o, 1'b0);
    chk("rd_latency", cycles, NB + 1 + stalls);
    chk("rd_line_o", bus.line_o, line);
    chk("rd_address_hold", bus.address_o, align(addr));
    if (!hold) bus.read_i = 1'b0;
    cyc();
    chk("rd_idle_resp_o", bus.resp_o, 1'b0);
    chk("rd_idle_read_o", bus.read_o, 1'b0);
    chk("rd_line_hold", bus.line_o, line);
  endtask

  // Writeback: the model queue holds the beats the memory should see, in order.
  task automatic write_xfer(input logic [31:0] addr, input logic [LB-1:0] line,
                            input int pat_len, input logic [31:0] pat, input bit also_read);
    logic [BB-1:0] q[$];
    int n = 0, stalls = 0, cycles;
    logic r;
    for (int i = 0; i < NB; i++) q.push_back(line[i*BB +: BB]);
    bus.write_i   = 1'b1;
    bus.read_i    = also_read;
    bus.address_i = addr;
    bus.line_i    = line;
    cyc();
    cycles = 1;
    bus.line_i = rnd_line();  // the buffer must already hold the latched copy
    chk("wr_address_o", bus.address_o, align(addr));
    while (q.size() > 0 && n < 64) begin
      r = (pat_len > 0) ? pat[n] : ($urandom_range(0, 3) != 0);
      chk("wr_write_o", bus.write_o, 1'b1);
      chk("wr_read_o", bus.read_o, 1'b0);
      chk("wr_burst_o", bus.burst_o, q[0]);
      bus.resp_i  = r;
      bus.burst_i = $urandom;
      cyc();
      cycles++;
      n++;
      if (r) void'(q.pop_front()); else stalls++;
    end
    if (q.size() > 0) chk("wr_timeout", q.size(), 0);
    bus.resp_i = 1'b0;
    chk("wr_resp_o", bus.resp_o, 1'b1);
    chk("wr_write_o_done", bus.write_o, 1'b0);
    chk("wr_latency", cycles, NB + 1 + stalls);
    bus.write_i = 1'b0;
    bus.read_i  = 1'b0;
    cyc();
    chk("wr_idle_resp_o", bus.resp_o, 1'b0);
    chk("wr_idle_write_o", bus.write_o, 1'b0);
  endtask

  initial begin
    logic [LB-1:0] l1, l2;
    logic [31:0]   a;

    // Reset held for two cycles while the inputs are random.
    rst = 1'b1;
    bus.read_i = $urandom; bus.write_i = $urandom; bus.address_i = $urandom;
    bus.line_i = rnd_line(); bus.burst_i = $urandom; bus.resp_i = $urandom;
    cyc();
    cyc();
    chk_all_zero("rst");
    bus.read_i = 0; bus.write_i = 0; bus.resp_i = 0; bus.address_i = 0;
    rst = 1'b0;
    cyc();
    chk("rst_idle_resp_o", bus.resp_o, 1'b0);

    // Directed read with no stalls.
    l1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    read_xfer(32'h0000_1234, l1, 4, 32'hF, 1'b0);
    chk("rd_dir_addr_const", align(32'h0000_1234), 32'h0000_1220);

    // Directed write with the resp_i pattern 1,0,1,0,1,1.
    write_xfer(32'h0000_0040, {64'hD, 64'hC, 64'hB, 64'hA}, 6, 32'b110101, 1'b0);

    // Simultaneous requests: the writeback wins.
    write_xfer(32'hABCD_EF17, rnd_line(), 0, 32'h0, 1'b1);

    // Reset in the middle of a read.
    bus.read_i = 1'b1; bus.address_i = 32'h0000_8888;
    cyc();
    bus.resp_i = 1'b1; bus.burst_i = 64'h1111_2222_3333_4444;
    cyc();
    bus.burst_i = 64'h5555_6666_7777_8888;
    cyc();
    rst = 1'b1;
    cyc();
    chk_all_zero("rst_mid");
    rst = 1'b0; bus.read_i = 1'b0; bus.resp_i = 1'b0;
    cyc();
    chk("rst_mid_no_resp", bus.resp_o, 1'b0);
    chk("rst_mid_no_read", bus.read_o, 1'b0);
    read_xfer(32'h0000_9000, rnd_line(), 0, 32'h0, 1'b0);

    // Back-to-back reads with read_i held between them.
    l1 = rnd_line();
    l2 = rnd_line();
    read_xfer(32'h0001_0000, l1, 0, 32'h0, 1'b1);
    read_xfer(32'h0002_0020, l2, 0, 32'h0, 1'b0);

    // Randomized mix of reads and writes.
    for (int t = 0; t < 24; t++) begin
      a = $urandom;
      if ($urandom_range(0, 1) != 0) read_xfer(a, rnd_line(), 0, 32'h0, 1'b0);
      else write_xfer(a, rnd_line(), 0, 32'h0, $urandom_range(0, 1) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
